if_id_buffer: RTL
=================

Name: if_id_buffer

Overview:
- Decoupling instruction buffer between the instruction fetch unit and the instruction decode unit.
- Accepts {pc, inst} pairs from fetch over a valid/ready handshake and holds them in a small circular FIFO.
- Presents the oldest pair to decode over a second valid/ready handshake.
- A flush input discards all buffered instructions on a control-flow redirect.

Parameters:
- DEPTH, 2, number of entries; power of two, DEPTH >= 2.
- XLEN, 32, width of pc and inst fields.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  fetch presents a valid {in_pc, in_inst}.
- in_ready  output  1  buffer can accept a pair this cycle.
- in_pc  input  XLEN  pc of fetched instruction.
- in_inst  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode consumes head this cycle.
- out_pc  output  XLEN  pc of head entry.
- out_inst  output  XLEN  instruction of head entry.
- flush  input  1  synchronous discard of all entries (redirect).
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset: asynchronous, active-high; clk and rst are the only clock/reset. While rst=1, and on the first edge after release:
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_pc=0, out_inst=0.
  - in_ready=0 during reset; in_ready=1 from the first cycle after release.
  - Storage array is not reset.
- Enqueue (enq) = in_valid & in_ready & ~flush. Writes {in_pc, in_inst} at wr_ptr; wr_ptr advances by 1 modulo DEPTH (natural wrap).
- Dequeue (deq) = out_valid & out_ready & ~flush. rd_ptr advances by 1 modulo DEPTH.
- Occupancy update:
  - count +1 on enq only, -1 on deq only.
  - Unchanged when both or neither occur.
- in_ready = ~rst & ~flush & (count != DEPTH).
  - Does not depend on out_ready; there is no combinational path from out_ready to in_ready.
  - When full, a same-cycle dequeue does not make in_ready high; the slot frees on the next cycle.
- Output side:
  - out_valid = (count != 0).
  - out_pc/out_inst = entry[rd_ptr] when out_valid, else 0.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Latency: no bypass. A pair enqueued at edge N is visible on out_* in the cycle after edge N (one-cycle latency), including when the buffer was empty.
- Flush:
  - Takes precedence over enq and deq in the same cycle.
  - At the next edge: rd_ptr=wr_ptr=0, count=0.
  - Incoming pair in the flush cycle is dropped.
  - out_valid stays combinationally derived from count: it is still asserted during the flush cycle if count != 0, but deq is suppressed.
- Back-to-back flushes are legal; each is idempotent.
- Full + in_valid: no write occurs; fetch must hold in_pc/in_inst until handshake.
- Empty + out_ready: no pointer change; out_pc/out_inst read 0.
- Reset asserted mid-transfer: all state cleared immediately (asynchronous); any in-flight handshake is abandoned.
- count never exceeds DEPTH or underflows below 0; an assertion in the bench checks this every cycle.

Test Plan:
- Single transfer: after reset, in_valid=1, in_pc=0x80000000, in_inst=0x00000413, out_ready=1.
  - Cycle after edge: out_valid=1, out_pc=0x80000000, out_inst=0x00000413.
  - Following cycle: count=0, out_inst=0.
- Fill to full: out_ready=0; enqueue pcs 0x80000000 and 0x80000004 (DEPTH=2).
  - count=2, in_ready=0.
  - A third in_valid with pc 0x80000008 is not accepted; out_pc stays 0x80000000.
- Simultaneous enq/deq at count=1: in_valid=1, out_ready=1 for 6 cycles with pcs incrementing by 4.
  - count stays 1.
  - out_pc sequence is exactly the input sequence delayed one cycle.
  - Pointers wrap past DEPTH with no loss or duplication.
- Flush priority: count=2, assert flush with in_valid=1 (pc 0x80000010) and out_ready=1.
  - Next cycle: count=0, out_valid=0, in_ready=1.
  - pc 0x80000010 never appears on out_pc.
- Async reset mid-operation: count=2, assert rst between clock edges.
  - Immediately: out_valid=0, in_ready=0, count=0, out_pc=0.
  - After release: first enqueued pc (0x80000000) emerges first.
- Random stress: 10k cycles of random in_valid/out_ready/flush (flush at 2% of cycles).
  - Scoreboard matches in-order delivery between flushes.
  - count within 0..DEPTH at all times.

Source files
------------

// File: rtl/if_id_buffer.sv
// -----------------------------------------------------------------------------
// if_id_buffer
//
// Decoupling buffer between instruction fetch and instruction decode. Fetched
// {pc, inst} pairs are accepted over a valid/ready handshake, held in a small
// circular FIFO, and the oldest pair is presented to decode over a second
// valid/ready handshake. A flush discards everything on a redirect.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   XLEN   width of the pc and instruction fields
//
// Ports
//   clk        system clock, rising-edge
//   rst        asynchronous active-high reset
//   in_valid   fetch presents a pair
//   in_ready   buffer accepts a pair this cycle
//   in_pc      pc of the fetched instruction
//   in_inst    fetched instruction word
//   out_valid  head entry is valid for decode
//   out_ready  decode consumes the head this cycle
//   out_pc     pc of the head entry (0 when empty)
//   out_inst   instruction of the head entry (0 when empty)
//   flush      synchronous discard of all entries
//   count      number of occupied entries
// -----------------------------------------------------------------------------
module if_id_buffer #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_inst,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Storage is deliberately left out of reset; occupancy alone decides
   // which entries are meaningful.
   logic [XLEN-1:0] r_pc_mem   [DEPTH];
   logic [XLEN-1:0] r_inst_mem [DEPTH];

   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;

   logic            w_full;
   logic            w_empty;
   logic            w_enq;
   logic            w_deq;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // in_ready looks only at registered occupancy: a dequeue in the same cycle
   // does not open a slot until the next cycle, so there is no combinational
   // path from out_ready to in_ready.
   assign in_ready  = ~rst & ~flush & ~w_full;
   assign out_valid = ~w_empty;

   // Flush overrides both handshakes.
   assign w_enq = in_valid & in_ready & ~flush;
   assign w_deq = out_valid & out_ready & ~flush;

   // Control state: pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage, written only on an accepted enqueue.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_pc_mem[r_wr_ptr]   <= in_pc;
         r_inst_mem[r_wr_ptr] <= in_inst;
      end
   end

   // Head is read straight from storage (no bypass), forced to zero when empty.
   assign out_pc   = w_empty ? '0 : r_pc_mem[r_rd_ptr];
   assign out_inst = w_empty ? '0 : r_inst_mem[r_rd_ptr];
   assign count    = r_count;

endmodule
